// File: rtl/recip_nr_refine.sv
// -----------------------------------------------------------------------------
// recip_nr_refine
//
// Computes 1/d for a divisor d = 1 + d_in/2^WIDTH in [1,2).
// - Uses d_in to address an external sbtm bipartite table.
// - Adds the two returned partial terms to form a seed.
// - Refines the seed with ITER Newton-Raphson steps x' = x*(2 - d*x).
// - A single shared multiplier serves both half-steps of every iteration.
// - The result is unsigned Q1.WIDTH.
//
// Configuration macro:
//   RECIP_ROUND_EN  When defined, the x*e product is rounded half-up before
//                   it is truncated. Otherwise the product is only truncated.
//                   Latency and handshake are the same in both builds.
//
// Ports:
//   Clk    in   1        clock, rising edge
//   Rst    in   1        asynchronous reset, active-high
//   start  in   1        request, accepted only in IDLE or DONE
//   d_in   in   WIDTH    divisor fraction
//   ia_in  out  7        sbtm table address (top 7 bits of d_in), combinational
//   p0     in   10       sbtm partial term 0, sampled in the accept cycle
//   p1     in   10       sbtm partial term 1, sampled in the accept cycle
//   busy   out  1        high while multiplying (MUL_A / MUL_B)
//   done   out  1        one-cycle pulse when x_out holds a fresh result
//   x_out  out  WIDTH+1  result 1/d, Q1.WIDTH, held until the next completion
// -----------------------------------------------------------------------------
module recip_nr_refine #(
  parameter int WIDTH = 16,
  parameter int ITER  = 2
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             start,
  input  logic [WIDTH-1:0] d_in,
  output logic [6:0]       ia_in,
  input  logic [9:0]       p0,
  input  logic [9:0]       p1,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   x_out
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL_A,
    ST_MUL_B,
    ST_DONE
  } state_t;

  localparam int PW = 2 * WIDTH + 4;

  // 2.0 in Q2.WIDTH. It is both the NR constant and the saturation threshold.
  localparam logic [WIDTH+1:0] TWO_Q2    = (WIDTH+2)'(2) << WIDTH;
  localparam logic [WIDTH:0]   X_MAX     = '1;
  localparam logic [1:0]       LAST_ITER = 2'(ITER - 1);

  state_t state_q, state_d;

  logic [WIDTH:0]   divisor_q, divisor_d;
  logic [WIDTH:0]   xEst_q, xEst_d;
  logic [WIDTH+1:0] tProd_q, tProd_d;
  logic [1:0]       iterCount_q, iterCount_d;
  logic [WIDTH:0]   xOut_q, xOut_d;

  logic             accept;
  logic             lastIter;
  logic [10:0]      seedSum;
  logic [WIDTH:0]   seedX;
  logic [WIDTH+1:0] errTerm;
  logic [WIDTH+1:0] mulOpA, mulOpB;
  logic [PW-1:0]    mulProd;
  logic [PW-1:0]    roundAdd;
  logic [PW-1:0]    prodAdj;
  logic [PW-1:0]    prodScaled;
  logic [WIDTH:0]   xNext;

  assign ia_in    = d_in[WIDTH-1:WIDTH-7];
  assign accept   = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign lastIter = (iterCount_q == LAST_ITER);

  // The seed is Q1.10 from the table. Widen it to Q1.WIDTH.
  // The 11-bit sum cannot wrap.
  assign seedSum = {1'b0, p0} + {1'b0, p1};
  assign seedX   = (WIDTH+1)'(seedSum) << (WIDTH - 10);

  // If d*x has already reached 2.0, the correction term would go negative.
  // Clamp it to zero instead of letting it wrap.
  always_comb begin
    errTerm = TWO_Q2 - tProd_q;
    if (tProd_q >= TWO_Q2) begin
      errTerm = '0;
    end
  end

  // Shared multiplier operands:
  //   MUL_A computes d*x.
  //   MUL_B computes x*e.
  always_comb begin
    mulOpA = {1'b0, divisor_q};
    mulOpB = {1'b0, xEst_q};
    if (state_q == ST_MUL_B) begin
      mulOpA = {1'b0, xEst_q};
      mulOpB = errTerm;
    end
  end

  assign mulProd = mulOpA * mulOpB;

`ifdef RECIP_ROUND_EN
  // Half an output LSB, added only to the x*e product.
  // It is added ahead of the saturation check.
  assign roundAdd = (state_q == ST_MUL_B) ? (PW'(1) << (WIDTH - 1)) : '0;
`else
  assign roundAdd = '0;
`endif

  assign prodAdj    = mulProd + roundAdd;
  assign prodScaled = prodAdj >> WIDTH;

  // Saturate to just below 2.0 so the estimate always fits Q1.WIDTH.
  assign xNext = (prodScaled >= PW'(TWO_Q2)) ? X_MAX : prodScaled[WIDTH:0];

  // State register.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  state_d = start ? ST_MUL_A : ST_IDLE;
      ST_MUL_A: state_d = ST_MUL_B;
      ST_MUL_B: state_d = lastIter ? ST_DONE : ST_MUL_A;
      ST_DONE:  state_d = start ? ST_MUL_A : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs, decoded from the state.
  always_comb begin
    busy = (state_q == ST_MUL_A) || (state_q == ST_MUL_B);
    done = (state_q == ST_DONE);
  end

  assign x_out = xOut_q;

  // Datapath next values.
  // - Operands are captured only on accept.
  // - x_out changes only on the final MUL_B.
  always_comb begin
    divisor_d   = divisor_q;
    xEst_d      = xEst_q;
    tProd_d     = tProd_q;
    iterCount_d = iterCount_q;
    xOut_d      = xOut_q;
    if (accept) begin
      divisor_d   = {1'b1, d_in};
      xEst_d      = seedX;
      iterCount_d = '0;
    end
    if (state_q == ST_MUL_A) begin
      tProd_d = prodScaled[WIDTH+1:0];
    end
    if (state_q == ST_MUL_B) begin
      xEst_d      = xNext;
      iterCount_d = iterCount_q + 2'd1;
      if (lastIter) begin
        xOut_d = xNext;
      end
    end
  end

  // Datapath registers.
  // Reset clears them so that an in-flight result is dropped.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      divisor_q   <= '0;
      xEst_q      <= '0;
      tProd_q     <= '0;
      iterCount_q <= '0;
      xOut_q      <= '0;
    end else begin
      divisor_q   <= divisor_d;
      xEst_q      <= xEst_d;
      tProd_q     <= tProd_d;
      iterCount_q <= iterCount_d;
      xOut_q      <= xOut_d;
    end
  end

endmodule

// File: tb/tb_recip_nr_refine.sv
// -----------------------------------------------------------------------------
// tb_recip_nr_refine
//
// Directed and model-based checks for recip_nr_refine (WIDTH=16, ITER=2).
// A behavioural sbtm table drives p0/p1 from ia_in when useModel is high.
// Otherwise, the directed seed terms are used.
// -----------------------------------------------------------------------------
module tb_recip_nr_refine;

  localparam int WIDTH = 16;
  localparam int ITER  = 2;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        start;
  logic [15:0] d_in;
  logic [6:0]  ia_in;
  logic [9:0]  p0, p1;
  logic [9:0]  dirP0, dirP1;
  logic [9:0]  modelP0, modelP1;
  logic        useModel;
  logic        busy, done;
  logic [16:0] x_out;

  int checkCount = 0;
  int errorCount = 0;

  recip_nr_refine #(.WIDTH(WIDTH), .ITER(ITER)) dut (
    .Clk   (Clk),
    .Rst   (Rst),
    .start (start),
    .d_in  (d_in),
    .ia_in (ia_in),
    .p0    (p0),
    .p1    (p1),
    .busy  (busy),
    .done  (done),
    .x_out (x_out)
  );

  // Free-running clock, 10 time units per period.
  always #5 Clk = ~Clk;

  // Behavioural sbtm model.
  // The seed is round(1024 / d_mid), where d_mid is the midpoint of the
  // ia_in interval. It is split into two partial terms.
  function automatic int sbtmSeed(input logic [6:0] ia);
    int den;
    den = 257 + 2 * int'(ia);
    return (262144 + den / 2) / den;
  endfunction

  always_comb begin
    int s;
    s = sbtmSeed(ia_in);
    modelP1 = 10'(s % 16);
    modelP0 = 10'(s - (s % 16));
  end

  assign p0 = useModel ? modelP0 : dirP0;
  assign p1 = useModel ? modelP1 : dirP1;

  // Bit-accurate reference for the refinement loop.
  function automatic logic [16:0] refModel(input logic [15:0] d, input int seed);
    longint dR, x, t, e, p;
    dR = 65536 + longint'(d);
    x  = longint'(seed) << 6;
    for (int i = 0; i < ITER; i++) begin
      t = (dR * x) >> 16;
      e = (t >= 131072) ? 0 : 131072 - t;
      p = x * e;
`ifdef RECIP_ROUND_EN
      p = p + 32768;
`endif
      p = p >> 16;
      x = (p >= 131072) ? 131071 : p;
    end
    return 17'(x);
  endfunction

  // Counts one comparison and reports a mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Waits for done, bounded by a cycle budget.
  // lat is the number of cycles after the accept edge, or -1 on timeout.
  task automatic waitDone(output int lat);
    lat = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge Clk);
      if (done) begin
        lat = i + 1;
        break;
      end
    end
  endtask

  // Issues a one-cycle start and scrambles d_in while busy.
  // Returns the result and its latency.
  task automatic applyStimulus(input logic [15:0] d, input logic useMdl,
                               input logic [9:0] a, input logic [9:0] b,
                               output logic [16:0] res, output int lat);
    @(negedge Clk);
    d_in     = d;
    useModel = useMdl;
    dirP0    = a;
    dirP1    = b;
    start    = 1'b1;
    #1;
    checkOutput("iaIn", 32'(ia_in), 32'(d >> 9));
    @(negedge Clk);
    start = 1'b0;
    d_in  = ~d;
    waitDone(lat);
    res = x_out;
  endtask

  initial begin
    logic [16:0] res;
    int          lat;
    int          doneSeen;
    logic [15:0] vals [3];
    logic [16:0] expX;
    real         ideal, diff;

    Rst      = 1'b1;
    start    = 1'b0;
    d_in     = '0;
    useModel = 1'b0;
    dirP0    = '0;
    dirP1    = '0;

    @(negedge Clk);
    checkOutput("resetBusy", 32'(busy), 32'd0);
    checkOutput("resetDone", 32'(done), 32'd0);
    checkOutput("resetXout", 32'(x_out), 32'd0);
    Rst = 1'b0;

    // d = 1.0 with an exact seed. The result 1.0 must not saturate.
    applyStimulus(16'h0000, 1'b0, 10'h300, 10'h100, res, lat);
    checkOutput("oneLat", 32'(lat), 32'd4);
    checkOutput("oneX", 32'(res), 32'h10000);
    @(negedge Clk);
    checkOutput("donePulse", 32'(done), 32'd0);
    checkOutput("xHeld", 32'(x_out), 32'h10000);

    // d = 1.5 with seed 0x2AB.
    applyStimulus(16'h8000, 1'b0, 10'h2A0, 10'h00B, res, lat);
`ifdef RECIP_ROUND_EN
    checkOutput("threeHalvesX", 32'(res), 32'h0AAAB);
`else
    checkOutput("threeHalvesX", 32'(res), 32'h0AAAA);
`endif
    checkOutput("threeHalvesLat", 32'(lat), 32'd4);

    // d just below 2, with seed 0.5. The address must be 7'h7F.
    applyStimulus(16'hFFFF, 1'b0, 10'h200, 10'h000, res, lat);
    checkOutput("nearTwoX", 32'(res), 32'h08000);

    // A zero seed keeps x at zero. The operation must not hang.
    applyStimulus(16'h1234, 1'b0, 10'h000, 10'h000, res, lat);
    checkOutput("zeroSeedLat", 32'(lat), 32'd4);
    checkOutput("zeroSeedX", 32'(res), 32'd0);

    // An oversized seed drives d*x past 2.0.
    // The correction clamps to zero and the result collapses to 0.
    applyStimulus(16'hFFFF, 1'b0, 10'h3FF, 10'h3FF, res, lat);
    checkOutput("clampX", 32'(res), 32'd0);

    // A table-driven seed, checked against the reference.
    applyStimulus(16'h4C3A, 1'b1, 10'h000, 10'h000, res, lat);
    checkOutput("modelX", 32'(res), 32'(refModel(16'h4C3A, sbtmSeed(7'h26))));

    // start held high: chained accepts through DONE, and starts while
    // busy are ignored.
    vals[0] = 16'h1000;
    vals[1] = 16'h2000;
    vals[2] = 16'h3000;
    @(negedge Clk);
    useModel = 1'b1;
    start    = 1'b1;
    for (int r = 0; r < 3; r++) begin
      d_in = vals[r];
      @(negedge Clk);
      d_in = 16'hFFFF;
      waitDone(lat);
      checkOutput("chainLat", 32'(lat), 32'd4);
      checkOutput("chainX", 32'(x_out), 32'(refModel(vals[r], sbtmSeed(vals[r][15:9]))));
    end
    start = 1'b0;
    @(negedge Clk);

    // Reset in MUL_B drops the operation and clears x_out.
    @(negedge Clk);
    d_in  = 16'h8000;
    start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    @(negedge Clk);
    #1 Rst = 1'b1;
    #1;
    checkOutput("rstMidBusy", 32'(busy), 32'd0);
    checkOutput("rstMidXout", 32'(x_out), 32'd0);
    @(negedge Clk);
    Rst = 1'b0;
    doneSeen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge Clk);
      if (done) doneSeen++;
    end
    checkOutput("rstNoDone", 32'(doneSeen), 32'd0);

    // Random sweep. Each result must match the reference exactly and
    // stay within 2 ULP of the real-valued 1/d.
    for (int n = 0; n < 3000; n++) begin
      logic [15:0] d;
      d = 16'($urandom);
      applyStimulus(d, 1'b1, 10'h000, 10'h000, res, lat);
      expX = refModel(d, sbtmSeed(d[15:9]));
      checkOutput("sweepX", 32'(res), 32'(expX));
      ideal = 4294967296.0 / (65536.0 + real'(d));
      diff  = real'(res) - ideal;
      checkOutput("sweepUlp", 32'((diff <= 2.0) && (diff >= -2.0)), 32'd1);
    end

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
